// File: rtl/clock_disp_pkg.sv
// Shared types, segment codes and helpers for the time display driver.
// Segment constants are stored in active-low form, bit6=g ... bit0=a.
package clock_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        LATCH = 2'd2
    } dispState_e;

    localparam int CONV_CYCLES = 24;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [9:0][6:0] DIGIT_CODES = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    function automatic logic [7:0] adjustHours(input logic [7:0] hrs, input logic mode12h);
        logic [7:0] result;
        result = hrs;
        if (mode12h) begin
            if (hrs == 8'd0) begin
                result = 8'd12;
            end else if (hrs >= 8'd13 && hrs <= 8'd23) begin
                result = hrs - 8'd12;
            end
        end
        return result;
    endfunction

    // Shift-add-3 correction applied to every BCD nibble before each shift.
    function automatic logic [11:0] dabbleAdjust(input logic [11:0] bcd);
        logic [11:0] result;
        result = bcd;
        for (int i = 0; i < 3; i++) begin
            if (result[4*i +: 4] >= 4'd5) begin
                result[4*i +: 4] = result[4*i +: 4] + 4'd3;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_encode.sv
// Combinational BCD-to-seven-segment encoder with blank and dash overrides.
// Blank wins over dash; non-decimal nibbles also render blank.
module seg_encode
    import clock_disp_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_o
);

    logic [6:0] codeLow;

    always_comb begin
        codeLow = SEG_BLANK;
        if (blank_i) begin
            codeLow = SEG_BLANK;
        end else if (dash_i) begin
            codeLow = SEG_DASH;
        end else if (bcd_i <= 4'd9) begin
            codeLow = DIGIT_CODES[bcd_i];
        end
        seg_o = SEG_ACTIVE_LOW ? codeLow : ~codeLow;
    end

endmodule

// File: rtl/time_display_driver.sv
// Serial binary-to-BCD display driver: snapshots sec/min/hrs, converts them
// with one shared double-dabble engine, and drives six registered digits.
module time_display_driver
    import clock_disp_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_HR_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_2hz,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic [7:0] hrs,
    input  logic       mode_12h,
    input  logic       blink_min,
    input  logic       blink_hr,
    output logic [6:0] SEC_LSD,
    output logic [6:0] SEC_MSD,
    output logic [6:0] MIN_LSD,
    output logic [6:0] MIN_MSD,
    output logic [6:0] HR_LSD,
    output logic [6:0] HR_MSD,
    output logic       pm,
    output logic       upd
);

    localparam logic [6:0] BLANK_OUT = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    dispState_e state_q, state_d;

    logic [7:0]  snapSec_q, snapMin_q, snapHrs_q;
    logic        snapMode_q, snapPm_q;
    logic [4:0]  convCnt_q;
    logic [7:0]  shiftBin_q;
    logic [11:0] shiftBcd_q;
    logic [2:0][11:0] convRes_q;
    logic [2:0][11:0] dispBcd_q;
    logic        dispPm_q;
    logic        valid_q;
    logic        upd_q;
    logic        phase_q;
    logic [5:0][6:0] segOut_q;
    logic        pm_q;

    logic [7:0]  hrsAdj;
    logic        pmNow;
    logic        inputChanged;
    logic        startConv;
    logic        latchNow;
    logic        convDone;
    logic [1:0]  fieldIdx;
    logic [2:0]  bitIdx;
    logic [11:0] bcdAdj;
    logic [11:0] stepBcd;
    logic [7:0]  nextOperand;
    logic [5:0][6:0] segNext;

    // pm is tracked alongside hrs_adj because 1 and 13 share the same 12h value.
    assign hrsAdj       = adjustHours(hrs, mode_12h);
    assign pmNow        = mode_12h && (hrs >= 8'd12);
    assign inputChanged = {sec, min, hrsAdj, mode_12h, pmNow}
                       != {snapSec_q, snapMin_q, snapHrs_q, snapMode_q, snapPm_q};

    assign fieldIdx = convCnt_q[4:3];
    assign bitIdx   = convCnt_q[2:0];
    assign convDone = (convCnt_q == 5'(CONV_CYCLES - 1));
    assign bcdAdj   = dabbleAdjust(shiftBcd_q);
    assign stepBcd  = {bcdAdj[10:0], shiftBin_q[7]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        startConv = 1'b0;
        latchNow  = 1'b0;
        case (state_q)
            IDLE: begin
                if (inputChanged) begin
                    startConv = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                if (convDone) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                latchNow = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nextOperand = 8'd0;
        case (fieldIdx)
            2'd0:    nextOperand = snapMin_q;
            2'd1:    nextOperand = snapHrs_q;
            default: nextOperand = 8'd0;
        endcase
    end

    // One bit per cycle; the engine reloads with the next field after bit 7.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapSec_q  <= 8'hFF;
            snapMin_q  <= 8'hFF;
            snapHrs_q  <= 8'hFF;
            snapMode_q <= 1'b1;
            snapPm_q   <= 1'b1;
            convCnt_q  <= '0;
            shiftBin_q <= '0;
            shiftBcd_q <= '0;
            convRes_q  <= '0;
        end else if (startConv) begin
            snapSec_q  <= sec;
            snapMin_q  <= min;
            snapHrs_q  <= hrsAdj;
            snapMode_q <= mode_12h;
            snapPm_q   <= pmNow;
            convCnt_q  <= '0;
            shiftBin_q <= sec;
            shiftBcd_q <= '0;
        end else if (state_q == CONV) begin
            convCnt_q <= convCnt_q + 5'd1;
            if (bitIdx == 3'd7) begin
                case (fieldIdx)
                    2'd0:    convRes_q[0] <= stepBcd;
                    2'd1:    convRes_q[1] <= stepBcd;
                    2'd2:    convRes_q[2] <= stepBcd;
                    default: ;
                endcase
                shiftBcd_q <= '0;
                shiftBin_q <= nextOperand;
            end else begin
                shiftBcd_q <= stepBcd;
                shiftBin_q <= {shiftBin_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dispBcd_q <= '0;
            dispPm_q  <= 1'b0;
            valid_q   <= 1'b0;
            upd_q     <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            upd_q <= latchNow;
            if (latchNow) begin
                dispBcd_q <= convRes_q;
                dispPm_q  <= snapPm_q;
                valid_q   <= 1'b1;
            end
            if (tick_2hz) begin
                phase_q <= ~phase_q;
            end
        end
    end

    logic secDash, minDash, hrDash;
    logic secBlank, minBlank, hrBlank, hrLeadBlank;

    always_comb begin
        secDash     = dispBcd_q[0][11:8] != 4'd0;
        minDash     = dispBcd_q[1][11:8] != 4'd0;
        hrDash      = dispBcd_q[2][11:8] != 4'd0;
        secBlank    = !valid_q;
        minBlank    = !valid_q || (blink_min && phase_q);
        hrBlank     = !valid_q || (blink_hr && phase_q);
        hrLeadBlank = mode_12h && BLANK_HR_LZ && !hrDash && (dispBcd_q[2][7:4] == 4'd0);
    end

    seg_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) uSecLsd (
        .bcd_i(dispBcd_q[0][3:0]), .blank_i(secBlank), .dash_i(secDash), .seg_o(segNext[0])
    );
    seg_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) uSecMsd (
        .bcd_i(dispBcd_q[0][7:4]), .blank_i(secBlank), .dash_i(secDash), .seg_o(segNext[1])
    );
    seg_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) uMinLsd (
        .bcd_i(dispBcd_q[1][3:0]), .blank_i(minBlank), .dash_i(minDash), .seg_o(segNext[2])
    );
    seg_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) uMinMsd (
        .bcd_i(dispBcd_q[1][7:4]), .blank_i(minBlank), .dash_i(minDash), .seg_o(segNext[3])
    );
    seg_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) uHrLsd (
        .bcd_i(dispBcd_q[2][3:0]), .blank_i(hrBlank), .dash_i(hrDash), .seg_o(segNext[4])
    );
    seg_encode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) uHrMsd (
        .bcd_i(dispBcd_q[2][7:4]), .blank_i(hrBlank || hrLeadBlank), .dash_i(hrDash),
        .seg_o(segNext[5])
    );

    // Output stage refreshes every cycle so blink changes bypass the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            segOut_q <= {6{BLANK_OUT}};
            pm_q     <= 1'b0;
        end else begin
            segOut_q <= segNext;
            pm_q     <= dispPm_q && mode_12h;
        end
    end

    assign SEC_LSD = segOut_q[0];
    assign SEC_MSD = segOut_q[1];
    assign MIN_LSD = segOut_q[2];
    assign MIN_MSD = segOut_q[3];
    assign HR_LSD  = segOut_q[4];
    assign HR_MSD  = segOut_q[5];
    assign pm      = pm_q;
    assign upd     = upd_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Self-checking bench for time_display_driver: a timeline model of the
// display predicts every output each cycle, plus directed literal checks.
module tb_time_display_driver;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    logic       clk;
    logic       reset;
    logic       tick_2hz;
    logic [7:0] sec, min, hrs;
    logic       mode_12h, blink_min, blink_hr;
    logic [6:0] SEC_LSD, SEC_MSD, MIN_LSD, MIN_MSD, HR_LSD, HR_MSD;
    logic       pm, upd;

    int compared   = 0;
    int mismatched = 0;

    time_display_driver #(.SEG_ACTIVE_LOW(1'b1), .BLANK_HR_LZ(1'b1)) dut (
        .clk(clk), .reset(reset), .tick_2hz(tick_2hz),
        .sec(sec), .min(min), .hrs(hrs),
        .mode_12h(mode_12h), .blink_min(blink_min), .blink_hr(blink_hr),
        .SEC_LSD(SEC_LSD), .SEC_MSD(SEC_MSD), .MIN_LSD(MIN_LSD),
        .MIN_MSD(MIN_MSD), .HR_LSD(HR_LSD), .HR_MSD(HR_MSD),
        .pm(pm), .upd(upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] segCode(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic int hourShown(input int h, input bit md);
        if (!md) return h;
        if (h == 0) return 12;
        if (h >= 13 && h <= 23) return h - 12;
        return h;
    endfunction

    task automatic pairExpect(input int v, input bit blankPair, input bit leadBlank,
                              output logic [6:0] msd, output logic [6:0] lsd);
        if (blankPair) begin
            msd = BLANK; lsd = BLANK;
        end else if (v > 99) begin
            msd = DASH; lsd = DASH;
        end else begin
            msd = (leadBlank && (v / 10) == 0) ? BLANK : segCode(v / 10);
            lsd = segCode(v % 10);
        end
    endtask

    // Model: a snapshot is taken when idle inputs differ from the last one;
    // 25 edges later the snapshot becomes the displayed time (upd high),
    // and the registered digits follow one edge after that.
    bit         mArmed = 0;
    bit         mBusy, mSnapValid, mLatValid, mPhase;
    int         mCnt;
    int         mSnapSec, mSnapMin, mSnapHrs;
    bit         mSnapMode;
    int         mLatSec, mLatMin, mLatHrs;
    bit         mLatMode;
    logic [6:0] expSeg [6];
    logic       expPm, expUpd;

    always @(posedge clk) begin
        mArmed = 1;
        if (reset) begin
            mBusy = 0; mSnapValid = 0; mLatValid = 0; mPhase = 0; mCnt = 0;
            for (int k = 0; k < 6; k++) expSeg[k] = BLANK;
            expPm  = 0;
            expUpd = 0;
        end else begin
            if (!mLatValid) begin
                for (int k = 0; k < 6; k++) expSeg[k] = BLANK;
                expPm = 0;
            end else begin
                pairExpect(mLatSec, 1'b0, 1'b0, expSeg[1], expSeg[0]);
                pairExpect(mLatMin, blink_min && mPhase, 1'b0, expSeg[3], expSeg[2]);
                pairExpect(hourShown(mLatHrs, mLatMode), blink_hr && mPhase, mode_12h,
                           expSeg[5], expSeg[4]);
                expPm = mLatMode && (mLatHrs >= 12) && mode_12h;
            end
            expUpd = 0;
            if (!mBusy) begin
                if (!mSnapValid || sec != mSnapSec[7:0] || min != mSnapMin[7:0] ||
                    hrs != mSnapHrs[7:0] || mode_12h != mSnapMode) begin
                    mSnapSec = sec; mSnapMin = min; mSnapHrs = hrs; mSnapMode = mode_12h;
                    mSnapValid = 1; mBusy = 1; mCnt = 0;
                end
            end else begin
                mCnt++;
                if (mCnt == 25) begin
                    mLatSec = mSnapSec; mLatMin = mSnapMin; mLatHrs = mSnapHrs;
                    mLatMode = mSnapMode; mLatValid = 1; expUpd = 1; mBusy = 0;
                end
            end
            if (tick_2hz) mPhase = !mPhase;
        end
    end

    task automatic checkOutput(input string name, input logic [6:0] act, input logic [6:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mArmed) begin
            checkOutput("model SEC_LSD", SEC_LSD, expSeg[0]);
            checkOutput("model SEC_MSD", SEC_MSD, expSeg[1]);
            checkOutput("model MIN_LSD", MIN_LSD, expSeg[2]);
            checkOutput("model MIN_MSD", MIN_MSD, expSeg[3]);
            checkOutput("model HR_LSD", HR_LSD, expSeg[4]);
            checkOutput("model HR_MSD", HR_MSD, expSeg[5]);
            checkOutput("model pm", {6'd0, pm}, {6'd0, expPm});
            checkOutput("model upd", {6'd0, upd}, {6'd0, expUpd});
        end
    end

    task automatic applyStimulus(input int s, input int m, input int h, input bit md);
        @(negedge clk);
        sec = 8'(s); min = 8'(m); hrs = 8'(h); mode_12h = md;
    endtask

    task automatic waitUpd(input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (upd) begin
                cycles = i;
                break;
            end
        end
        if (cycles < 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL updTimeout at %0t: got no upd within %0d cycles", $time, bound);
        end
    endtask

    initial begin
        int c;
        reset = 1'b1; tick_2hz = 1'b0; blink_min = 1'b0; blink_hr = 1'b0;
        sec = 8'd0; min = 8'd0; hrs = 8'd0; mode_12h = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset SEC_LSD", SEC_LSD, BLANK);
        checkOutput("reset HR_MSD", HR_MSD, BLANK);
        checkOutput("reset upd", {6'd0, upd}, 7'd0);
        checkOutput("reset pm", {6'd0, pm}, 7'd0);

        // First conversion after reset: 00:00:00 in 24h mode
        reset = 1'b0;
        waitUpd(30, c);
        @(negedge clk);
        checkOutput("zero SEC_LSD", SEC_LSD, segCode(0));
        checkOutput("zero SEC_MSD", SEC_MSD, segCode(0));
        checkOutput("zero MIN_LSD", MIN_LSD, segCode(0));
        checkOutput("zero MIN_MSD", MIN_MSD, segCode(0));
        checkOutput("zero HR_LSD", HR_LSD, segCode(0));
        checkOutput("zero HR_MSD", HR_MSD, segCode(0));
        checkOutput("zero pm", {6'd0, pm}, 7'd0);
        repeat (3) @(negedge clk);

        // 23:34:59 and the exact input-to-upd latency
        applyStimulus(59, 34, 23, 1'b0);
        waitUpd(40, c);
        checkOutput("latency 26", 7'(c), 7'd26);
        @(negedge clk);
        checkOutput("t23 HR_MSD", HR_MSD, segCode(2));
        checkOutput("t23 HR_LSD", HR_LSD, segCode(3));
        checkOutput("t23 MIN_MSD", MIN_MSD, segCode(3));
        checkOutput("t23 MIN_LSD", MIN_LSD, segCode(4));
        checkOutput("t23 SEC_MSD", SEC_MSD, segCode(5));
        checkOutput("t23 SEC_LSD", SEC_LSD, segCode(9));

        // 12-hour mode boundaries: midnight, 13h, noon
        applyStimulus(59, 34, 0, 1'b1);
        waitUpd(40, c); @(negedge clk);
        checkOutput("h0 HR_MSD", HR_MSD, segCode(1));
        checkOutput("h0 HR_LSD", HR_LSD, segCode(2));
        checkOutput("h0 pm", {6'd0, pm}, 7'd0);
        applyStimulus(59, 34, 13, 1'b1);
        waitUpd(40, c); @(negedge clk);
        checkOutput("h13 HR_MSD", HR_MSD, BLANK);
        checkOutput("h13 HR_LSD", HR_LSD, segCode(1));
        checkOutput("h13 pm", {6'd0, pm}, 7'd1);
        applyStimulus(59, 34, 12, 1'b1);
        waitUpd(40, c); @(negedge clk);
        checkOutput("h12 HR_MSD", HR_MSD, segCode(1));
        checkOutput("h12 HR_LSD", HR_LSD, segCode(2));
        checkOutput("h12 pm", {6'd0, pm}, 7'd1);

        // Out-of-range seconds render as dashes
        applyStimulus(150, 34, 12, 1'b0);
        waitUpd(40, c); @(negedge clk);
        checkOutput("s150 SEC_MSD", SEC_MSD, DASH);
        checkOutput("s150 SEC_LSD", SEC_LSD, DASH);
        checkOutput("s150 MIN_MSD", MIN_MSD, segCode(3));
        checkOutput("s150 MIN_LSD", MIN_LSD, segCode(4));
        checkOutput("s150 HR_MSD", HR_MSD, segCode(1));

        // Hour blink over four phase toggles
        @(negedge clk);
        blink_hr = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); tick_2hz = 1'b1;
            @(negedge clk); tick_2hz = 1'b0;
            @(negedge clk);
            checkOutput("blink HR_MSD", HR_MSD, (k % 2 == 1) ? BLANK : segCode(1));
            checkOutput("blink MIN_LSD", MIN_LSD, segCode(4));
        end
        blink_hr = 1'b0;
        repeat (2) @(negedge clk);

        // Seconds change in the middle of a conversion
        applyStimulus(10, 34, 12, 1'b0);
        repeat (11) @(negedge clk);
        sec = 8'd20;
        waitUpd(30, c); @(negedge clk);
        checkOutput("midconv old SEC_MSD", SEC_MSD, segCode(1));
        checkOutput("midconv old SEC_LSD", SEC_LSD, segCode(0));
        waitUpd(30, c); @(negedge clk);
        checkOutput("midconv new SEC_MSD", SEC_MSD, segCode(2));
        checkOutput("midconv new SEC_LSD", SEC_LSD, segCode(0));

        // Reset in the middle of a conversion
        applyStimulus(30, 34, 12, 1'b0);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checkOutput("abort upd", {6'd0, upd}, 7'd0);
        end
        checkOutput("abort SEC_LSD", SEC_LSD, BLANK);
        checkOutput("abort HR_MSD", HR_MSD, BLANK);
        reset = 1'b0;
        waitUpd(30, c); @(negedge clk);
        checkOutput("post-abort SEC_MSD", SEC_MSD, segCode(3));
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
